// File: rtl/calc_key_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : calc_key_sequencer
// Description : Turns keypad events into two decimal operands and an operator,
//               launches the arithmetic unit and holds result/error for display.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_key_sequencer #(
    parameter int DIGITS = 4,
    parameter int OPW    = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           key_code,
    input  logic                 key_pressed,
    input  logic                 alu_done,
    input  logic [2*OPW-1:0]     alu_result,
    input  logic                 alu_err,
    output logic [OPW-1:0]       opa,
    output logic [OPW-1:0]       opb,
    output logic [1:0]           op_sel,
    output logic                 alu_start,
    output logic                 busy,
    output logic [2*OPW-1:0]     disp_value,
    output logic                 disp_err
);

    localparam int               c_CW        = $clog2(DIGITS + 1);
    localparam logic [c_CW-1:0]  c_CNT_MAX   = c_CW'(DIGITS);
    localparam logic [2*OPW-1:0] c_MAX_VALUE = (2*OPW)'(10**DIGITS - 1);

    localparam logic [7:0] c_KEY_ADD = 8'h82;
    localparam logic [7:0] c_KEY_SUB = 8'h84;
    localparam logic [7:0] c_KEY_MUL = 8'h88;
    localparam logic [7:0] c_KEY_DIV = 8'h28;
    localparam logic [7:0] c_KEY_EQ  = 8'h48;
    localparam logic [7:0] c_KEY_CLR = 8'h18;

    typedef enum logic [2:0] {
        ST_ENTER_A  = 3'd0,
        ST_ENTER_B  = 3'd1,
        ST_WAIT_ALU = 3'd2,
        ST_RESULT   = 3'd3,
        ST_ERROR    = 3'd4
    } state_t;

    state_t             r_state, w_state_n;
    logic               r_sync1, r_sync2, r_prev;
    logic [OPW-1:0]     r_opa, w_opa_n;
    logic [OPW-1:0]     r_opb, w_opb_n;
    logic [c_CW-1:0]    r_a_cnt, w_a_cnt_n;
    logic [c_CW-1:0]    r_b_cnt, w_b_cnt_n;
    logic [1:0]         r_op_sel, w_op_sel_n;
    logic [2*OPW-1:0]   r_result, w_result_n;
    logic [2*OPW-1:0]   r_disp, w_disp_n;
    logic               r_start, w_start_n;

    logic               w_evt, w_is_digit, w_is_op, w_is_eq, w_is_clr;
    logic [1:0]         w_op_code;
    logic [3:0]         w_digit;

    function automatic logic [OPW-1:0] f_acc(input logic [OPW-1:0] x, input logic [3:0] d);
        return (x << 3) + (x << 1) + {{(OPW-4){1'b0}}, d};
    endfunction

    // Single event per press: rising edge of the synchronized level
    assign w_evt      = r_sync2 & ~r_prev;
    assign w_digit    = key_code[3:0];
    assign w_is_digit = w_evt && (key_code <= 8'd9);
    assign w_is_eq    = w_evt && (key_code == c_KEY_EQ);
    assign w_is_clr   = w_evt && (key_code == c_KEY_CLR);

    always_comb begin
        w_is_op   = 1'b0;
        w_op_code = 2'b00;
        case (key_code)
            c_KEY_ADD: begin w_is_op = w_evt; w_op_code = 2'b00; end
            c_KEY_SUB: begin w_is_op = w_evt; w_op_code = 2'b01; end
            c_KEY_MUL: begin w_is_op = w_evt; w_op_code = 2'b10; end
            c_KEY_DIV: begin w_is_op = w_evt; w_op_code = 2'b11; end
            default:   ;
        endcase
    end

    always_comb begin
        w_state_n  = r_state;
        w_opa_n    = r_opa;
        w_opb_n    = r_opb;
        w_a_cnt_n  = r_a_cnt;
        w_b_cnt_n  = r_b_cnt;
        w_op_sel_n = r_op_sel;
        w_result_n = r_result;
        w_start_n  = 1'b0;
        w_disp_n   = r_disp;

        case (r_state)
            ST_ENTER_A: begin
                if (w_is_digit && (r_a_cnt < c_CNT_MAX)) begin
                    w_opa_n   = f_acc(r_opa, w_digit);
                    w_a_cnt_n = r_a_cnt + 1'b1;
                end else if (w_is_op) begin
                    w_op_sel_n = w_op_code;
                    w_opb_n    = '0;
                    w_b_cnt_n  = '0;
                    w_state_n  = ST_ENTER_B;
                end
            end
            ST_ENTER_B: begin
                if (w_is_digit && (r_b_cnt < c_CNT_MAX)) begin
                    w_opb_n   = f_acc(r_opb, w_digit);
                    w_b_cnt_n = r_b_cnt + 1'b1;
                end else if (w_is_op && (r_b_cnt == '0)) begin
                    w_op_sel_n = w_op_code;
                end else if (w_is_eq && (r_b_cnt != '0)) begin
                    w_start_n = 1'b1;
                    w_state_n = ST_WAIT_ALU;
                end
            end
            ST_WAIT_ALU: begin
                if (alu_done) begin
                    if (alu_err) begin
                        w_state_n = ST_ERROR;
                    end else begin
                        w_result_n = alu_result;
                        w_state_n  = ST_RESULT;
                    end
                end
            end
            ST_RESULT: begin
                if (w_is_digit) begin
                    w_opa_n   = {{(OPW-4){1'b0}}, w_digit};
                    w_a_cnt_n = c_CW'(1);
                    w_state_n = ST_ENTER_A;
                end else if (w_is_op) begin
                    // Chaining is only legal when the result fits an operand
                    if (r_result <= c_MAX_VALUE) begin
                        w_opa_n    = r_result[OPW-1:0];
                        w_op_sel_n = w_op_code;
                        w_opb_n    = '0;
                        w_b_cnt_n  = '0;
                        w_state_n  = ST_ENTER_B;
                    end else begin
                        w_state_n = ST_ERROR;
                    end
                end
            end
            default: ;
        endcase

        if (w_is_clr) begin
            w_state_n  = ST_ENTER_A;
            w_opa_n    = '0;
            w_opb_n    = '0;
            w_a_cnt_n  = '0;
            w_b_cnt_n  = '0;
            w_op_sel_n = 2'b00;
            w_result_n = '0;
            w_start_n  = 1'b0;
        end

        case (w_state_n)
            ST_ENTER_A: w_disp_n = {{OPW{1'b0}}, w_opa_n};
            ST_ENTER_B: w_disp_n = (w_b_cnt_n != '0) ? {{OPW{1'b0}}, w_opb_n}
                                                     : {{OPW{1'b0}}, w_opa_n};
            ST_RESULT:  w_disp_n = w_result_n;
            ST_ERROR:   w_disp_n = '0;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_prev   <= 1'b0;
            r_state  <= ST_ENTER_A;
            r_opa    <= '0;
            r_opb    <= '0;
            r_a_cnt  <= '0;
            r_b_cnt  <= '0;
            r_op_sel <= 2'b00;
            r_result <= '0;
            r_disp   <= '0;
            r_start  <= 1'b0;
        end else begin
            r_sync1  <= key_pressed;
            r_sync2  <= r_sync1;
            r_prev   <= r_sync2;
            r_state  <= w_state_n;
            r_opa    <= w_opa_n;
            r_opb    <= w_opb_n;
            r_a_cnt  <= w_a_cnt_n;
            r_b_cnt  <= w_b_cnt_n;
            r_op_sel <= w_op_sel_n;
            r_result <= w_result_n;
            r_disp   <= w_disp_n;
            r_start  <= w_start_n;
        end
    end

    assign opa        = r_opa;
    assign opb        = r_opb;
    assign op_sel     = r_op_sel;
    assign alu_start  = r_start;
    assign busy       = (r_state == ST_WAIT_ALU);
    assign disp_err   = (r_state == ST_ERROR);
    assign disp_value = r_disp;

endmodule
`default_nettype wire
